// File: rtl/axi_slave_mem.sv
// AXI4 slave word memory acting as a burst target for an AXI master.
// Serves one read or one write burst at a time (INCR or FIXED) and writes with byte strobes.
// It returns SLVERR for an out-of-range address, a beat size other than 4 bytes, a WRAP or
// reserved burst type, or a write whose wlast does not match awlen.
//
// Ports:
//   aclk, areset_n                           clock, async active-low reset
//   araddr/arlen/arsize/arburst/arvalid/arready   read address channel
//   rdata/rresp/rlast/rvalid/rready               read data channel
//   awaddr/awlen/awsize/awburst/awvalid/awready   write address channel
//   wdata/wstrb/wlast/wvalid/wready               write data channel
//   bresp/bvalid/bready                           write response channel
module axi_slave_mem #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                aclk,
  input  logic                areset_n,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned StrbW = DATA_W / 8;
  localparam logic [ADDR_W-1:0] MemBytes = ADDR_W'(DEPTH * 4);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StRdata, StWdata, StWresp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              fixed_q, fixed_d;
  logic              err_q, err_d;
  logic              over_q, over_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rlast_q, rlast_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;

  logic              ar_hs, aw_hs, r_hs, w_hs;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        a_size;
  logic [1:0]        a_burst;
  logic              a_err;
  logic [IdxW-1:0]   a_idx;
  logic [IdxW-1:0]   idx_nxt;

  // Ready is forced low while reset is held so every output reads 0 during reset.
  assign arready = areset_n && (state_q == StIdle);
  assign awready = areset_n && (state_q == StIdle) && !arvalid;
  assign wready  = (state_q == StWdata);
  assign rvalid  = (state_q == StRdata);
  assign bvalid  = (state_q == StWresp);
  assign rdata   = rdata_q;
  assign rlast   = rvalid && rlast_q;
  assign rresp   = (rvalid && err_q) ? RespSlvErr : RespOkay;
  assign bresp   = bvalid ? bresp_q : RespOkay;

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign r_hs  = rvalid && rready;
  assign w_hs  = wvalid && wready;

  // Read has priority, so the shared latch path takes the AR fields whenever AR handshakes.
  assign a_addr  = ar_hs ? araddr  : awaddr;
  assign a_size  = ar_hs ? arsize  : awsize;
  assign a_burst = ar_hs ? arburst : awburst;
  assign a_err   = (a_addr >= MemBytes) || (a_size != 3'b010) || a_burst[1];
  assign a_idx   = a_addr[IdxW+1:2];

  // INCR wraps naturally modulo DEPTH through the index width.
  assign idx_nxt = fixed_q ? idx_q : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    fixed_d = fixed_q;
    err_d   = err_q;
    over_d  = over_q;
    rdata_d = rdata_q;
    rlast_d = rlast_q;
    bresp_d = bresp_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ar_hs || aw_hs) begin
          idx_d   = a_idx;
          cnt_d   = '0;
          fixed_d = (a_burst == 2'b00);
          err_d   = a_err;
          over_d  = 1'b0;
        end
        if (ar_hs) begin
          state_d = StRdata;
          len_d   = arlen;
          rdata_d = a_err ? '0 : mem_q[a_idx];
          rlast_d = (arlen == 8'd0);
        end else if (aw_hs) begin
          state_d = StWdata;
          len_d   = awlen;
        end
      end
      StRdata: begin
        if (r_hs) begin
          if (rlast_q) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            idx_d   = idx_nxt;
            rdata_d = err_q ? '0 : mem_q[idx_nxt];
            rlast_d = ((cnt_q + 8'd1) == len_q);
          end
        end
      end
      StWdata: begin
        if (w_hs) begin
          // Beats past awlen are accepted but dropped and flagged in the response.
          mem_we = !err_q && !over_q;
          cnt_d  = cnt_q + 8'd1;
          idx_d  = idx_nxt;
          if (cnt_q == len_q) over_d = 1'b1;
          if (wlast) begin
            state_d = StWresp;
            bresp_d = (err_q || over_q || (cnt_q != len_q)) ? RespSlvErr : RespOkay;
          end
        end
      end
      StWresp: begin
        if (bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
      over_q  <= 1'b0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
      bresp_q <= RespOkay;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      fixed_q <= fixed_d;
      err_q   <= err_d;
      over_q  <= over_d;
      rdata_q <= rdata_d;
      rlast_q <= rlast_d;
      bresp_q <= bresp_d;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wstrb[b]) mem_q[idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  always #5 aclk = ~aclk;

  axi_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(16)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] model [16];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  typedef struct {
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    int          nbeats;
    logic [31:0] d0;
    logic [3:0]  strb;
    logic [1:0]  resp;
    bit          stall;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit bench_err(input logic [31:0] addr, input logic [2:0] size,
                                   input logic [1:0] burst);
    return (addr >= 32'h40) || (size != 3'd2) || burst[1];
  endfunction

  // R and B scoreboard: the head of each queue is the beat the DUT must be presenting.
  always @(negedge aclk) begin
    if (areset_n) begin
      if (rvalid) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 64'(rvalid), 64'd0);
        end else begin
          chk(rready ? "r_beat" : "r_hold", {rdata, rresp, rlast},
              {rq[0].d, rq[0].resp, rq[0].last});
          if (rready) void'(rq.pop_front());
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 64'(bvalid), 64'd0);
        end else begin
          chk("b_resp", 64'(bresp), 64'(bq[0]));
          if (bready) void'(bq.pop_front());
        end
      end
    end
  end

  task automatic wait_aw();
    int cyc = 0;
    @(negedge aclk);
    while (!awready && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    chk("aw_ready", 64'(awready), 64'd1);
  endtask

  task automatic wait_w();
    int cyc = 0;
    @(negedge aclk);
    while (!wready && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    chk("w_ready", 64'(wready), 64'd1);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((rq.size() + bq.size()) > 0 && cyc < 100) begin
      @(posedge aclk);
      cyc++;
    end
    chk("drain", 64'(rq.size() + bq.size()), 64'd0);
    rq.delete();
    bq.delete();
  endtask

  // Beats come from wd/ws; wlast is raised on the final beat sent.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input int nbeats, input logic [1:0] exp_resp);
    logic [3:0] idx;
    bit err;
    idx = addr[5:2];
    err = bench_err(addr, size, burst);
    for (int i = 0; i < nbeats; i++) begin
      if (!err && i <= int'(len)) begin
        for (int b = 0; b < 4; b++) if (ws[i][b]) model[idx][8*b +: 8] = wd[i][8*b +: 8];
      end
      if (burst != 2'b00) idx = idx + 4'd1;
    end
    bq.push_back(exp_resp);
    @(posedge aclk); #1;
    awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    wait_aw();
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
      wait_w();
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [1:0] exp_resp, input bit stall);
    logic [3:0] idx;
    bit err;
    logic [3:0] pat;
    int k;
    int cyc;
    rexp_t e;
    pat = 4'b1001;
    idx = addr[5:2];
    err = bench_err(addr, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      e.d = err ? 32'd0 : model[idx];
      e.resp = exp_resp;
      e.last = (i == int'(len));
      rq.push_back(e);
      if (burst != 2'b00) idx = idx + 4'd1;
    end
    @(posedge aclk); #1;
    araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    cyc = 0;
    @(negedge aclk);
    while (!arready && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    chk("ar_ready", 64'(arready), 64'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    k = 0;
    cyc = 0;
    while (rq.size() > 0 && cyc < 100) begin
      rready = stall ? pat[k % 4] : 1'b1;
      k++;
      @(posedge aclk); #1;
      cyc++;
    end
    rready = 1'b1;
    chk("r_done", 64'(rq.size()), 64'd0);
    rq.delete();
  endtask

  task automatic add(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                     input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                     input logic [31:0] d0, input logic [3:0] strb, input logic [1:0] resp,
                     input bit stall);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.size = size;
    v.nbeats = nbeats; v.d0 = d0; v.strb = strb; v.resp = resp; v.stall = stall;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) model[i] = '0;

    // wr  addr    len burst size nb  d0            strb  resp  stall
    add(1, 32'h04, 3, 2'b01, 3'd2, 4, 32'hdeadbeef, 4'hf, 2'b00, 0);
    add(0, 32'h04, 3, 2'b01, 3'd2, 0, 32'h0,        4'h0, 2'b00, 0);
    add(0, 32'h04, 3, 2'b01, 3'd2, 0, 32'h0,        4'h0, 2'b00, 1);
    add(1, 32'h08, 0, 2'b01, 3'd2, 1, 32'h11223344, 4'hf, 2'b00, 0);
    add(0, 32'h40, 1, 2'b01, 3'd2, 0, 32'h0,        4'h0, 2'b10, 0);
    add(1, 32'h00, 3, 2'b01, 3'd2, 2, 32'h00001000, 4'hf, 2'b10, 0);
    add(0, 32'h00, 1, 2'b01, 3'd2, 0, 32'h0,        4'h0, 2'b00, 0);
    add(1, 32'h38, 3, 2'b01, 3'd2, 4, 32'h000000a0, 4'hf, 2'b00, 0);
    add(0, 32'h38, 3, 2'b01, 3'd2, 0, 32'h0,        4'h0, 2'b00, 1);
    add(1, 32'h10, 0, 2'b01, 3'd2, 2, 32'h00000055, 4'hf, 2'b10, 0);
    add(0, 32'h10, 1, 2'b01, 3'd2, 0, 32'h0,        4'h0, 2'b00, 0);
    add(0, 32'h00, 0, 2'b01, 3'd3, 0, 32'h0,        4'h0, 2'b10, 0);
    add(1, 32'h20, 0, 2'b10, 3'd2, 1, 32'h12345678, 4'hf, 2'b10, 0);
    add(0, 32'h20, 0, 2'b01, 3'd2, 0, 32'h0,        4'h0, 2'b00, 0);

    // Reset state
    #2;
    chk("rst_outputs", {arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp, rdata},
        64'd0);
    @(posedge aclk); #1;
    areset_n = 1'b1;
    @(negedge aclk);
    chk("idle_ready", {arready, awready}, 2'b11);

    foreach (vt[n]) begin
      if (vt[n].wr) begin
        for (int i = 0; i < vt[n].nbeats; i++) begin
          wd[i] = vt[n].d0 + 32'(i);
          ws[i] = vt[n].strb;
        end
        do_write(vt[n].addr, vt[n].len, vt[n].burst, vt[n].size, vt[n].nbeats, vt[n].resp);
        @(negedge aclk);
        chk("bvalid_latency", 64'(bvalid), 64'd1);
        drain();
      end else begin
        do_read(vt[n].addr, vt[n].len, vt[n].burst, vt[n].size, vt[n].resp, vt[n].stall);
      end
      // Keep the byte-strobe case adjacent to its full-word setup write.
      if (n == 3) begin
        wd[0] = 32'haabbccdd; ws[0] = 4'h3;
        wd[1] = 32'h00000000; ws[1] = 4'h0;
        do_write(32'h08, 8'd1, 2'b00, 3'd2, 2, 2'b00);
        drain();
        do_read(32'h08, 8'd0, 2'b01, 3'd2, 2'b00, 0);
        chk("strobe_model", model[2], 32'h1122ccdd);
      end
    end

    // Arbitration: simultaneous AR and AW, read wins and AW waits for the rlast handshake
    @(posedge aclk); #1;
    araddr = 32'h04; arlen = 8'd1; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    awaddr = 32'h30; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    rq.push_back('{d: model[1], resp: 2'b00, last: 1'b0});
    rq.push_back('{d: model[2], resp: 2'b00, last: 1'b1});
    @(negedge aclk);
    chk("arb_arready", 64'(arready), 64'd1);
    chk("arb_awready", 64'(awready), 64'd0);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    cyc = 0;
    @(negedge aclk);
    while (!awready && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    chk("aw_after_read", {awready, (rq.size() == 0)}, 2'b11);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    model[12] = 32'h77;
    bq.push_back(2'b00);
    wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hf; wlast = 1'b1;
    wait_w();
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    drain();
    do_read(32'h30, 8'd0, 2'b01, 3'd2, 2'b00, 0);

    // Reset during beat 2 of a write burst
    @(posedge aclk); #1;
    awaddr = 32'h0; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    wait_aw();
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1; wdata = 32'hcafe0000 + 32'(i); wstrb = 4'hf; wlast = 1'b0;
      wait_w();
      @(posedge aclk); #1;
    end
    wvalid = 1'b1; wdata = 32'hcafe0002;
    #2;
    areset_n = 1'b0;
    #1;
    chk("rst_async", {arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp, rdata},
        64'd0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    @(posedge aclk); #1;
    areset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      chk("no_b_after_rst", 64'(bvalid), 64'd0);
    end
    chk("idle_after_rst", {arready, awready, wready}, 3'b110);
    do_read(32'h00, 8'd3, 2'b01, 3'd2, 2'b00, 0);
    do_read(32'h30, 8'd0, 2'b01, 3'd2, 2'b00, 0);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
